// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: W-bit input, three registered
// BCD digits, busy/valid handshake so the display never sees partial results.
module bin2bcd_seq #(
  parameter int W    = 9,
  parameter bit AUTO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] bin,
  input  logic         start,
  output logic         busy,
  output logic         valid,
  output logic [3:0]   BCD0,
  output logic [3:0]   BCD1,
  output logic [3:0]   BCD2
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  shift_reg, shift_next;
  logic [W-1:0]  last_reg, last_next;
  logic [11:0]   scratch_reg, scratch_next;
  logic [11:0]   digits_reg, digits_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          valid_reg, valid_next;

  logic [11:0]   adj;
  logic [W+11:0] shifted;
  logic          trigger;

  // Add-3 correction applied to each scratch nibble independently before the shift.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                              ? scratch_reg[gi*4 +: 4] + 4'd3
                              : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // The bit leaving the hundreds nibble falls off the top and is dropped.
  assign shifted = {adj, shift_reg} << 1;
  assign trigger = start || (AUTO && (bin != last_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      last_reg    <= '0;
      scratch_reg <= '0;
      digits_reg  <= '0;
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      last_reg    <= last_next;
      scratch_reg <= scratch_next;
      digits_reg  <= digits_next;
      cnt_reg     <= cnt_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    last_next    = last_reg;
    scratch_next = scratch_reg;
    digits_next  = digits_reg;
    cnt_next     = cnt_reg;
    valid_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          shift_next   = bin;
          scratch_next = '0;
          last_next    = bin;
          cnt_next     = CW'(W);
          state_next   = CONV;
        end
      end
      CONV: begin
        scratch_next = shifted[W+11:W];
        shift_next   = shifted[W-1:0];
        cnt_next     = cnt_reg - CW'(1);
        // Last shift: publish digits straight from the shifted value.
        if (cnt_reg == CW'(1)) begin
          digits_next = shifted[W+11:W];
          valid_next  = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg == CONV);
  assign valid = valid_reg;
  assign BCD0  = digits_reg[3:0];
  assign BCD1  = digits_reg[7:4];
  assign BCD2  = digits_reg[11:8];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: one DUT with AUTO=0 (start-driven) and one with AUTO=1 (change-driven);
// drivers push expected BCD digits, a negedge monitor pops and compares on each valid.
module tb_bin2bcd_seq;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] bin0 = '0, bin1 = '0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, valid0, busy1, valid1;
  logic [3:0] d0_0, d1_0, d2_0, d0_1, d1_1, d2_1;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  int n_pass = 0;
  int n_checks = 0;

  bin2bcd_seq #(.W(W), .AUTO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bin(bin0), .start(start0),
    .busy(busy0), .valid(valid0), .BCD0(d0_0), .BCD1(d1_0), .BCD2(d2_0));

  bin2bcd_seq #(.W(W), .AUTO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bin(bin1), .start(start1),
    .busy(busy1), .valid(valid1), .BCD0(d0_1), .BCD1(d1_1), .BCD2(d2_1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [11:0] dig(input bit s);
    return s ? {d2_1, d1_1, d0_1} : {d2_0, d1_0, d0_0};
  endfunction

  function automatic logic bsy(input bit s);
    return s ? busy1 : busy0;
  endfunction

  function automatic logic vld(input bit s);
    return s ? valid1 : valid0;
  endfunction

  // Entered and left at #1 after a rising edge. sel=0 pulses start, sel=1 changes bin.
  task automatic convert(input bit s, input int v, input logic [11:0] e);
    if (s) begin
      q1.push_back(e);
      bin1 = W'(v);
    end else begin
      q0.push_back(e);
      bin0 = W'(v);
      start0 = 1'b1;
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    chk($sformatf("busy after trigger v=%0d", v), int'(bsy(s)), 1);
    repeat (W - 1) @(posedge clk);
    #1;
    chk($sformatf("busy before last step v=%0d", v), int'(bsy(s)), 1);
    chk($sformatf("no early valid v=%0d", v), int'(vld(s)), 0);
    @(posedge clk); #1;
    chk($sformatf("busy drop at t+W v=%0d", v), int'(bsy(s)), 0);
    chk($sformatf("valid at t+W v=%0d", v), int'(vld(s)), 1);
    @(posedge clk); #1;
    chk($sformatf("valid one cycle v=%0d", v), int'(vld(s)), 0);
    chk($sformatf("digits held v=%0d", v), int'(dig(s)), int'(e));
  endtask

  // Monitor: compare digits against the scoreboard whenever valid is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid0) begin
        chk("dut0 busy with valid", int'(busy0), 0);
        if (q0.size() == 0) chk("dut0 unexpected valid", 1, 0);
        else chk("dut0 digits", int'({d2_0, d1_0, d0_0}), int'(q0.pop_front()));
      end
      if (valid1) begin
        chk("dut1 busy with valid", int'(busy1), 0);
        if (q1.size() == 0) chk("dut1 unexpected valid", 1, 0);
        else chk("dut1 digits", int'({d2_1, d1_1, d0_1}), int'(q1.pop_front()));
      end
    end
  end

  // Directed vectors and their hand-computed BCD digits.
  int          vec_bin[8] = '{0, 9, 10, 99, 100, 255, 256, 511};
  logic [11:0] vec_exp[8] = '{12'h000, 12'h009, 12'h010, 12'h099,
                              12'h100, 12'h255, 12'h256, 12'h511};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", int'(busy0), 0);
    chk("reset valid", int'(valid0), 0);
    chk("reset digits", int'(dig(0)), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle without start", int'(busy0), 0);

    convert(0, 511, 12'h511);
    repeat (3) @(posedge clk);
    #1;
    chk("511 held", int'(dig(0)), 12'h511);

    for (int i = 0; i < 8; i++) convert(0, vec_bin[i], vec_exp[i]);

    // start held high: one conversion every W+1 cycles
    q0.push_back(12'h255); q0.push_back(12'h255); q0.push_back(12'h255);
    bin0 = 9'd255; start0 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      repeat (k == 0 ? W : W + 1) @(posedge clk);
      #1;
      chk($sformatf("held start valid %0d", k), int'(valid0), 1);
    end
    start0 = 1'b0;
    @(posedge clk); #1;
    chk("held start stops", int'(busy0), 0);

    // start and bin change during CONV ignored
    q0.push_back(12'h123);
    bin0 = 9'd123; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bin0 = 9'd456; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ignore: valid at t+9", int'(valid0), 1);
    chk("ignore: digits 123", int'(dig(0)), 12'h123);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore: no retrigger", int'(busy0), 0);
    convert(0, 456, 12'h456);

    // async reset in the middle of a 511 conversion
    bin0 = 9'd511; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid reset busy", int'(busy0), 0);
    chk("mid reset valid", int'(valid0), 0);
    chk("mid reset digits", int'(dig(0)), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("after reset idle", int'(busy0), 0);
    chk("after reset digits", int'(dig(0)), 0);
    convert(0, 511, 12'h511);

    // sweep against a divide/modulo reference
    for (int v = 0; v < 512; v++)
      convert(0, v, 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10)));

    // AUTO mode: conversions only when bin changes
    repeat (5) @(posedge clk);
    #1;
    chk("auto idle on 0", int'(busy1), 0);
    convert(1, 37, 12'h037);
    repeat (10) @(posedge clk);
    #1;
    chk("auto unchanged bin idle", int'(busy1), 0);
    convert(1, 480, 12'h480);

    // change during CONV retriggers right after completion
    q1.push_back(12'h200); q1.push_back(12'h300);
    bin1 = 9'd200;
    @(posedge clk); #1;
    chk("auto mid: busy", int'(busy1), 1);
    repeat (3) @(posedge clk);
    #1 bin1 = 9'd300;
    repeat (5) @(posedge clk);
    #1;
    chk("auto mid: busy at t+8", int'(busy1), 1);
    @(posedge clk); #1;
    chk("auto mid: first valid", int'(valid1), 1);
    @(posedge clk); #1;
    chk("auto mid: retrigger", int'(busy1), 1);
    repeat (9) @(posedge clk);
    #1;
    chk("auto mid: second valid", int'(valid1), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("auto mid: idle after", int'(busy1), 0);

    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
